// File: rtl/header_pkg.sv
// Shared Ethernet header definitions for the transmit FSM and the receive-side parser.
// HEADER_TX_VLAN_EN inserts a 4-byte 802.1Q tag between SRC and TYPE_LEN.
package header_pkg;

`ifdef HEADER_TX_VLAN_EN
  localparam bit VLAN_EN = 1'b1;
`else
  localparam bit VLAN_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DST      = 3'd3,
    ST_SRC      = 3'd4,
    ST_VLAN     = 3'd5,
    ST_TYPE_LEN = 3'd6
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] VLAN_TPID     = 16'h8100;

  localparam int MAC_LEN  = 6;
  localparam int TL_LEN   = 2;
  localparam int VLAN_LEN = 4;

  // Position inside a header: current field and byte index within it.
  typedef struct packed {
    state_t     state;
    logic [3:0] idx;
  } pos_t;

  function automatic logic [3:0] last_idx(input state_t state, input logic [3:0] pre_last);
    case (state)
      ST_PREAMBLE:    last_idx = pre_last;
      ST_DST, ST_SRC: last_idx = 4'(MAC_LEN - 1);
      ST_VLAN:        last_idx = 4'(VLAN_LEN - 1);
      ST_TYPE_LEN:    last_idx = 4'(TL_LEN - 1);
      default:        last_idx = 4'd0;
    endcase
  endfunction

  // Position of the byte that follows cur once cur has been accepted.
  function automatic pos_t next_pos(input pos_t cur, input logic [3:0] pre_last);
    pos_t nxt;
    nxt = cur;
    if (cur.idx != last_idx(cur.state, pre_last)) begin
      nxt.idx = cur.idx + 4'd1;
    end else begin
      nxt.idx = 4'd0;
      case (cur.state)
        ST_PREAMBLE: nxt.state = ST_SFD;
        ST_SFD:      nxt.state = ST_DST;
        ST_DST:      nxt.state = ST_SRC;
        ST_SRC: begin
          if (VLAN_EN) nxt.state = ST_VLAN;
          else         nxt.state = ST_TYPE_LEN;
        end
        ST_VLAN:     nxt.state = ST_TYPE_LEN;
        default:     nxt.state = ST_IDLE;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/header_tx_byte_sel.sv
// Combinational header byte select: picks the byte for a given field/index
// from the latched header fields. The result is registered by the caller.
module header_tx_byte_sel
  import header_pkg::*;
(
  input  logic [2:0]  state,
  input  logic [3:0]  idx,
  input  logic [47:0] dst_addr,
  input  logic [47:0] src_addr,
  input  logic [15:0] type_length,
  input  logic [15:0] vlan_tci,
  output logic [7:0]  sel_data
);

  // MAC addresses go out MSB-first: index 0 is bits [47:40].
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] i);
    case (i)
      4'd0:    return mac[47:40];
      4'd1:    return mac[39:32];
      4'd2:    return mac[31:24];
      4'd3:    return mac[23:16];
      4'd4:    return mac[15:8];
      default: return mac[7:0];
    endcase
  endfunction

  always_comb begin
    // NOTE: default first so every path assigns sel_data and no latch is inferred.
    sel_data = 8'h00;
    case (state_t'(state))
      ST_PREAMBLE: sel_data = PREAMBLE_BYTE;
      ST_SFD:      sel_data = SFD_BYTE;
      ST_DST:      sel_data = mac_byte(dst_addr, idx);
      ST_SRC:      sel_data = mac_byte(src_addr, idx);
      ST_VLAN: begin
        case (idx[1:0])
          2'd0:    sel_data = VLAN_TPID[15:8];
          2'd1:    sel_data = VLAN_TPID[7:0];
          2'd2:    sel_data = vlan_tci[15:8];
          default: sel_data = vlan_tci[7:0];
        endcase
      end
      ST_TYPE_LEN: sel_data = idx[0] ? type_length[7:0] : type_length[15:8];
      default:     sel_data = 8'h00;
    endcase
  end

endmodule

// File: rtl/header_tx_fsm.sv
// Ethernet header transmitter: serialises preamble, SFD, DST, SRC, (VLAN) and
// type/length onto a valid/ready byte stream. VLAN tag enabled by HEADER_TX_VLAN_EN.
module header_tx_fsm
  import header_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7
)(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [47:0] dst_addr,
  input  logic [47:0] src_addr,
  input  logic [15:0] type_length,
  input  logic [15:0] vlan_tci,
  input  logic        ready,
  output logic [7:0]  data,
  output logic        valid,
  output logic        preamble_valid,
  output logic        dst_addr_valid,
  output logic        src_addr_valid,
  output logic        type_length_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);

  pos_t        pos;
  pos_t        succ;
  logic [47:0] dst_q;
  logic [47:0] src_q;
  logic [15:0] tl_q;
  logic [15:0] tci_q;
  logic [7:0]  sel_data;

  // Outputs are loaded with the byte for the successor position, so the next
  // byte is ready the same edge the current one is accepted.
  assign succ = next_pos(pos, PRE_LAST);

  header_tx_byte_sel u_byte_sel (
    .state       (succ.state),
    .idx         (succ.idx),
    .dst_addr    (dst_q),
    .src_addr    (src_q),
    .type_length (tl_q),
    .vlan_tci    (tci_q),
    .sel_data    (sel_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pos               <= '{state: ST_IDLE, idx: 4'd0};
      dst_q             <= '0;
      src_q             <= '0;
      tl_q              <= '0;
      tci_q             <= '0;
      data              <= 8'h00;
      valid             <= 1'b0;
      preamble_valid    <= 1'b0;
      dst_addr_valid    <= 1'b0;
      src_addr_valid    <= 1'b0;
      type_length_valid <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pos.state == ST_IDLE) begin
        if (start) begin
          dst_q             <= dst_addr;
          src_q             <= src_addr;
          tl_q              <= type_length;
          tci_q             <= vlan_tci;
          pos               <= '{state: ST_PREAMBLE, idx: 4'd0};
          data              <= PREAMBLE_BYTE;
          valid             <= 1'b1;
          preamble_valid    <= 1'b1;
          busy              <= 1'b1;
        end
      end else if (valid && ready) begin
        // Leaving the last TYPE_LEN byte lands in IDLE: flags clear, done pulses.
        pos               <= succ;
        data              <= sel_data;
        valid             <= (succ.state != ST_IDLE);
        busy              <= (succ.state != ST_IDLE);
        done              <= (succ.state == ST_IDLE);
        preamble_valid    <= (succ.state == ST_PREAMBLE) || (succ.state == ST_SFD);
        dst_addr_valid    <= (succ.state == ST_DST);
        src_addr_valid    <= (succ.state == ST_SRC);
        type_length_valid <= (succ.state == ST_VLAN) || (succ.state == ST_TYPE_LEN);
      end
    end
  end

endmodule

// File: tb/tb_header_tx_fsm.sv
// Self-checking bench for header_tx_fsm: directed vector table, corner-case
// sequences and randomized headers against a byte-queue reference model.
module tb_header_tx_fsm;

  localparam int PRE = 7;
`ifdef HEADER_TX_VLAN_EN
  localparam bit VLAN_ON = 1'b1;
`else
  localparam bit VLAN_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [47:0] dst_addr = '0;
  logic [47:0] src_addr = '0;
  logic [15:0] type_length = '0;
  logic [15:0] vlan_tci = '0;
  logic [7:0]  data;
  logic        valid, preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid;
  logic        busy, done;
  logic [3:0]  flags;

  assign flags = {preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid};

  header_tx_fsm #(.PREAMBLE_LEN(PRE)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .dst_addr          (dst_addr),
    .src_addr          (src_addr),
    .type_length       (type_length),
    .vlan_tci          (vlan_tci),
    .ready             (ready),
    .data              (data),
    .valid             (valid),
    .preamble_valid    (preamble_valid),
    .dst_addr_valid    (dst_addr_valid),
    .src_addr_valid    (src_addr_valid),
    .type_length_valid (type_length_valid),
    .busy              (busy),
    .done              (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: the header as an ordered list of {byte, phase flags}.
  typedef struct {
    logic [7:0] b;
    logic [3:0] f;
  } hb_t;
  hb_t exp_q[$];

  function automatic void build(input logic [47:0] d, input logic [47:0] s,
                                input logic [15:0] t, input logic [15:0] v);
    exp_q.delete();
    for (int i = 0; i < PRE; i++) exp_q.push_back('{8'h55, 4'b1000});
    exp_q.push_back('{8'hD5, 4'b1000});
    for (int i = 0; i < 6; i++) exp_q.push_back('{d[47-8*i -: 8], 4'b0100});
    for (int i = 0; i < 6; i++) exp_q.push_back('{s[47-8*i -: 8], 4'b0010});
    if (VLAN_ON) begin
      exp_q.push_back('{8'h81, 4'b0001});
      exp_q.push_back('{8'h00, 4'b0001});
      exp_q.push_back('{v[15:8], 4'b0001});
      exp_q.push_back('{v[7:0], 4'b0001});
    end
    exp_q.push_back('{t[15:8], 4'b0001});
    exp_q.push_back('{t[7:0], 4'b0001});
  endfunction

  // Directed vectors: ready applied this cycle, outputs expected this cycle.
  typedef struct {
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [3:0] exp_flags;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(input logic r, input logic v, input logic [7:0] d,
                                  input logic [3:0] f, input logic b, input logic dn);
    vecs.push_back('{r, v, d, f, b, dn});
  endfunction

  task automatic launch(input logic [47:0] d, input logic [47:0] s,
                        input logic [15:0] t, input logic [15:0] v);
    build(d, s, t, v);
    dst_addr    = d;
    src_addr    = s;
    type_length = t;
    vlan_tci    = v;
    ready       = 1'b1;
    start       = 1'b1;
    tick();
  endtask

  // Walks the expected queue against the stream; ends in the done cycle.
  task automatic send_and_check(input string tag, input bit rnd, input bit hold_start,
                                input bit scramble);
    int cyc = 0;
    bit acc;
    while (exp_q.size() > 0 && cyc < 200) begin
      check({tag, "_vbd"}, {valid, busy, done}, 3'b110);
      check({tag, "_data"}, data, exp_q[0].b);
      check({tag, "_flags"}, flags, exp_q[0].f);
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = rnd ? 1'($urandom_range(0, 1)) : hold_start;
      if (scramble && cyc == 1) dst_addr = 48'hAAAA_AAAA_AAAA;
      if (rnd) begin
        dst_addr    = 48'({$urandom(), $urandom()});
        src_addr    = 48'({$urandom(), $urandom()});
        type_length = 16'($urandom());
        vlan_tci    = 16'($urandom());
      end
      acc = ready;
      tick();
      if (acc) void'(exp_q.pop_front());
      cyc++;
    end
    check({tag, "_remaining"}, exp_q.size(), 0);
    exp_q.delete();
    start = hold_start;
    check({tag, "_end"}, {valid, busy, done, flags}, 7'b0010000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table: golden frame with a two-cycle stall on DST byte 03.
    for (int i = 0; i < PRE; i++) add_vec(1, 1, 8'h55, 4'b1000, 1, 0);
    add_vec(1, 1, 8'hD5, 4'b1000, 1, 0);
    add_vec(1, 1, 8'h01, 4'b0100, 1, 0);
    add_vec(1, 1, 8'h02, 4'b0100, 1, 0);
    add_vec(0, 1, 8'h03, 4'b0100, 1, 0);
    add_vec(0, 1, 8'h03, 4'b0100, 1, 0);
    add_vec(1, 1, 8'h03, 4'b0100, 1, 0);
    add_vec(1, 1, 8'h04, 4'b0100, 1, 0);
    add_vec(1, 1, 8'h05, 4'b0100, 1, 0);
    add_vec(1, 1, 8'h06, 4'b0100, 1, 0);
    for (int i = 0; i < 6; i++) add_vec(1, 1, 8'(255 - i), 4'b0010, 1, 0);
    if (VLAN_ON) begin
      add_vec(1, 1, 8'h81, 4'b0001, 1, 0);
      add_vec(1, 1, 8'h00, 4'b0001, 1, 0);
      add_vec(1, 1, 8'h20, 4'b0001, 1, 0);
      add_vec(1, 1, 8'h64, 4'b0001, 1, 0);
    end
    add_vec(1, 1, 8'h08, 4'b0001, 1, 0);
    add_vec(1, 1, 8'h00, 4'b0001, 1, 0);
    add_vec(1, 0, 8'h00, 4'b0000, 0, 1);
    add_vec(1, 0, 8'h00, 4'b0000, 0, 0);

    // Reset state
    #1 reset_n = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {data, valid, flags, busy, done}, '0);
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", {valid, busy, done}, 3'b000);

    // Golden frame through the vector table
    dst_addr = 48'h010203040506;
    src_addr = 48'hFFFEFDFCFBFA;
    type_length = 16'h0800;
    vlan_tci = 16'h2064;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("vec%0d", i), {valid, data, flags, busy, done},
            {vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_flags,
             vecs[i].exp_busy, vecs[i].exp_done});
      ready = vecs[i].rdy;
      tick();
    end

    // Same frame under random backpressure
    launch(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 16'h2064);
    send_and_check("backpressure", 1, 0, 0);
    tick();

    // dst_addr changed two cycles after start must not leak into the header
    launch(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 16'h2064);
    send_and_check("late_change", 0, 0, 1);
    tick();
    check("late_change_idle", {valid, busy, done}, 3'b000);

    // start held high: back-to-back headers with exactly one idle cycle
    launch(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 16'h2064);
    send_and_check("b2b_first", 0, 1, 0);
    tick();
    build(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 16'h2064);
    send_and_check("b2b_second", 0, 0, 0);
    tick();
    check("b2b_stop", {valid, busy, done}, 3'b000);

    // Reset during SRC byte FC: immediate clear, no done, clean restart
    launch(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 16'h2064);
    start = 1'b0;
    exp_q.delete();
    repeat (PRE + 1 + 6 + 3) tick();
    check("pre_reset_byte", {data, flags}, {8'hFC, 4'b0010});
    reset_n = 1'b0;
    #1;
    check("async_reset", {data, valid, flags, busy, done}, '0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("no_done_after_reset%0d", i), {valid, busy, done}, 3'b000);
    end
    launch(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 16'h2064);
    send_and_check("restart", 0, 0, 0);
    tick();

    // Randomized headers, random gaps, random ready and start noise
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      launch(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
             16'($urandom()), 16'($urandom()));
      send_and_check($sformatf("rand%0d", n), 1, 0, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
